// File: rtl/hazard_pkg.sv
// Shared hazard/interlock types for the 5-stage MIPS core.
// Holds the controller state encoding and the zero-register constant.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MDU_BUSY = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    localparam logic [4:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use / MFC0-use comparator: flags when the instruction in ID
// reads a register that the load or MFC0 in EX has not produced yet.
// Ports:
//   id_rs_addr, id_rt_addr  : source registers of the ID instruction
//   id_uses_rs, id_uses_rt  : which sources are actually read
//   idex_rd_addr            : destination of the EX instruction
//   idex_mem_read, idex_mfc0: EX instruction is a load / MFC0
//   hz                      : interlock required (combinational)
import hazard_pkg::*;

module hazard_detect (
    input  logic [4:0] id_rs_addr,
    input  logic [4:0] id_rt_addr,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    input  logic [4:0] idex_rd_addr,
    input  logic       idex_mem_read,
    input  logic       idex_mfc0,
    output logic       hz
);

    logic late_prod;
    logic rs_hit;
    logic rt_hit;

    // Only loads and MFC0 deliver their result too late to forward;
    // r0 is hard-wired so writing it never creates a dependency.
    assign late_prod = (idex_mem_read | idex_mfc0)
                     & (idex_rd_addr != ZERO_REG);

    assign rs_hit = id_uses_rs & (id_rs_addr == idex_rd_addr);
    assign rt_hit = id_uses_rt & (id_rt_addr == idex_rd_addr);

    assign hz = late_prod & (rs_hit | rt_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline interlock/sequencing controller: load-use stalls, iterative
// MDU occupancy of EX and exception/ERET flushes from MEM.
// Ports:
//   clk, resetn             : clock, async active-low reset
//   id_* / idex_*           : ID sources and EX producer info
//   idex_mdu_op/mdu_div     : EX holds MULT(U)/DIV(U), 1=divide
//   mem_exc_valid           : exception or ERET taken in MEM
//   pc/ifid/idex stall, idex/exmem bubble, three flushes, pc_exc_sel
//   mdu_start/abort/done    : MDU sequencing pulses
// Optional macro HAZARD_PERF_EN adds perf_ldstall_cnt and perf_mdu_cnt.
import hazard_pkg::*;

module hazard_ctrl #(
    parameter int DIV_CYCLES = 32,
    parameter int MUL_CYCLES = 4,
    parameter int CNT_W      = 6
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [4:0]  id_rs_addr,
    input  logic [4:0]  id_rt_addr,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic [4:0]  idex_rd_addr,
    input  logic        idex_mem_read,
    input  logic        idex_mfc0,
    input  logic        idex_mdu_op,
    input  logic        idex_mdu_div,
    input  logic        mem_exc_valid,
    output logic        pc_stall,
    output logic        ifid_stall,
    output logic        idex_stall,
    output logic        idex_bubble,
    output logic        exmem_bubble,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic        pc_exc_sel,
    output logic        mdu_start,
    output logic        mdu_abort,
`ifdef HAZARD_PERF_EN
    output logic        mdu_done,
    output logic [31:0] perf_ldstall_cnt,
    output logic [31:0] perf_mdu_cnt
`else
    output logic        mdu_done
`endif
);

    // The start cycle and the done cycle are both part of the
    // occupancy, hence the load value of N-2.
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 2);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 2);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             hz;
    logic             ld_stall;

    hazard_detect u_detect (
        .id_rs_addr    (id_rs_addr),
        .id_rt_addr    (id_rt_addr),
        .id_uses_rs    (id_uses_rs),
        .id_uses_rt    (id_uses_rt),
        .idex_rd_addr  (idex_rd_addr),
        .idex_mem_read (idex_mem_read),
        .idex_mfc0     (idex_mfc0),
        .hz            (hz)
    );

    // Load-use interlock is only honoured in RUN and loses to an
    // exception in MEM.
    assign ld_stall = resetn & (state == RUN)
                    & ~mem_exc_valid & hz;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= RUN;
            cnt   <= '0;
        end else if (mem_exc_valid) begin
            state <= FLUSH;
            cnt   <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (idex_mdu_op) begin
                        state <= MDU_BUSY;
                        cnt   <= idex_mdu_div ? DIV_LOAD : MUL_LOAD;
                    end
                end
                MDU_BUSY: begin
                    if (cnt == '0) begin
                        state <= RUN;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                FLUSH: begin
                    state <= RUN;
                    cnt   <= '0;
                end
                default: begin
                    state <= RUN;
                    cnt   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        pc_stall     = 1'b0;
        ifid_stall   = 1'b0;
        idex_stall   = 1'b0;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exmem_flush  = 1'b0;
        pc_exc_sel   = 1'b0;
        mdu_start    = 1'b0;
        mdu_abort    = 1'b0;
        mdu_done     = 1'b0;
        if (resetn) begin
            if (mem_exc_valid) begin
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
                pc_exc_sel  = 1'b1;
                mdu_abort   = (state == MDU_BUSY);
            end else begin
                case (state)
                    RUN: begin
                        if (idex_mdu_op) begin
                            // ID/EX is held, so no bubble even if
                            // a load-use hazard coincides.
                            mdu_start    = 1'b1;
                            pc_stall     = 1'b1;
                            ifid_stall   = 1'b1;
                            idex_stall   = 1'b1;
                            exmem_bubble = 1'b1;
                        end else if (hz) begin
                            pc_stall    = 1'b1;
                            ifid_stall  = 1'b1;
                            idex_bubble = 1'b1;
                        end
                    end
                    MDU_BUSY: begin
                        if (cnt == '0) begin
                            mdu_done = 1'b1;
                        end else begin
                            pc_stall     = 1'b1;
                            ifid_stall   = 1'b1;
                            idex_stall   = 1'b1;
                            exmem_bubble = 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_ldstall_cnt <= '0;
            perf_mdu_cnt     <= '0;
        end else begin
            if (ld_stall) begin
                perf_ldstall_cnt <= perf_ldstall_cnt + 32'd1;
            end
            if (state == MDU_BUSY) begin
                perf_mdu_cnt <= perf_mdu_cnt + 32'd1;
            end
        end
    end
`else
    logic unused_ld_stall;
    assign unused_ld_stall = ld_stall;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus
// randomized traffic against a cycle-count reference model.
module tb_hazard_ctrl;

    localparam int DIV_N = 32;
    localparam int MUL_N = 4;

    localparam logic [11:0] V_NONE  = 12'b0000_0000_0000;
    localparam logic [11:0] V_LDUSE = 12'b1101_0000_0000;
    localparam logic [11:0] V_MDUST = 12'b1110_1000_0000;
    localparam logic [11:0] V_START = 12'b1110_1000_0100;
    localparam logic [11:0] V_DONE  = 12'b0000_0000_0001;
    localparam logic [11:0] V_EXC   = 12'b0000_0111_1000;
    localparam logic [11:0] V_ABORT = 12'b0000_0111_1010;

    logic       clk;
    logic       resetn;
    logic [4:0] id_rs_addr;
    logic [4:0] id_rt_addr;
    logic       id_uses_rs;
    logic       id_uses_rt;
    logic [4:0] idex_rd_addr;
    logic       idex_mem_read;
    logic       idex_mfc0;
    logic       idex_mdu_op;
    logic       idex_mdu_div;
    logic       mem_exc_valid;
    logic       pc_stall, ifid_stall, idex_stall;
    logic       idex_bubble, exmem_bubble;
    logic       ifid_flush, idex_flush, exmem_flush;
    logic       pc_exc_sel, mdu_start, mdu_abort, mdu_done;
    logic [11:0] outv;
    logic [11:0] exp_v;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_ldstall_cnt;
    logic [31:0] perf_mdu_cnt;
    int unsigned m_ld;
    int unsigned m_mdu;
`endif

    int checks;
    int errors;

    // Reference model: remaining EX occupancy of the MDU op (in
    // cycles still to come) and a pending post-exception dead cycle.
    int busy_left;
    bit flush_q;

    hazard_ctrl dut (
        .clk              (clk),
        .resetn           (resetn),
        .id_rs_addr       (id_rs_addr),
        .id_rt_addr       (id_rt_addr),
        .id_uses_rs       (id_uses_rs),
        .id_uses_rt       (id_uses_rt),
        .idex_rd_addr     (idex_rd_addr),
        .idex_mem_read    (idex_mem_read),
        .idex_mfc0        (idex_mfc0),
        .idex_mdu_op      (idex_mdu_op),
        .idex_mdu_div     (idex_mdu_div),
        .mem_exc_valid    (mem_exc_valid),
        .pc_stall         (pc_stall),
        .ifid_stall       (ifid_stall),
        .idex_stall       (idex_stall),
        .idex_bubble      (idex_bubble),
        .exmem_bubble     (exmem_bubble),
        .ifid_flush       (ifid_flush),
        .idex_flush       (idex_flush),
        .exmem_flush      (exmem_flush),
        .pc_exc_sel       (pc_exc_sel),
        .mdu_start        (mdu_start),
        .mdu_abort        (mdu_abort),
`ifdef HAZARD_PERF_EN
        .mdu_done         (mdu_done),
        .perf_ldstall_cnt (perf_ldstall_cnt),
        .perf_mdu_cnt     (perf_mdu_cnt)
`else
        .mdu_done         (mdu_done)
`endif
    );

    assign outv = {pc_stall, ifid_stall, idex_stall, idex_bubble,
                   exmem_bubble, ifid_flush, idex_flush, exmem_flush,
                   pc_exc_sel, mdu_start, mdu_abort, mdu_done};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit model_hz();
        return (idex_mem_read || idex_mfc0) && idex_rd_addr != 0 &&
               ((id_uses_rs && id_rs_addr == idex_rd_addr) ||
                (id_uses_rt && id_rt_addr == idex_rd_addr));
    endfunction

    function automatic logic [11:0] model_eval();
        if (!resetn)             return V_NONE;
        if (mem_exc_valid)       return busy_left > 0 ? V_ABORT : V_EXC;
        if (flush_q)             return V_NONE;
        if (busy_left == 1)      return V_DONE;
        if (busy_left > 1)       return V_MDUST;
        if (idex_mdu_op)         return V_START;
        if (model_hz())          return V_LDUSE;
        return V_NONE;
    endfunction

    task automatic model_reset();
        busy_left = 0;
        flush_q   = 0;
`ifdef HAZARD_PERF_EN
        m_ld  = 0;
        m_mdu = 0;
`endif
    endtask

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_commit();
`ifdef HAZARD_PERF_EN
        if (!mem_exc_valid && !flush_q && busy_left == 0 && model_hz())
            m_ld++;
        if (busy_left > 0)
            m_mdu++;
`endif
        if (mem_exc_valid) begin
            busy_left = 0;
            flush_q   = 1;
        end else if (flush_q) begin
            flush_q = 0;
        end else if (busy_left > 0) begin
            busy_left--;
        end else if (idex_mdu_op) begin
            busy_left = (idex_mdu_div ? DIV_N : MUL_N) - 1;
        end
    endtask

    task automatic set_in(input logic [4:0] rs, input logic [4:0] rt,
                          input logic urs, input logic urt,
                          input logic [4:0] rd, input logic mr,
                          input logic mf, input logic mop,
                          input logic mdiv, input logic exc);
        id_rs_addr    = rs;
        id_rt_addr    = rt;
        id_uses_rs    = urs;
        id_uses_rt    = urt;
        idex_rd_addr  = rd;
        idex_mem_read = mr;
        idex_mfc0     = mf;
        idex_mdu_op   = mop;
        idex_mdu_div  = mdiv;
        mem_exc_valid = exc;
        #1;
    endtask

    task automatic idle_in();
        set_in(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        model_reset();
        set_in(5'd5, 5'd0, 1, 0, 5'd5, 1, 0, 1, 1, 0);
        checks++;
        if (outv !== V_NONE) begin
            errors++;
            $display("FAIL reset_out got %b want %b", outv, V_NONE);
        end
`ifdef HAZARD_PERF_EN
        checks++;
        if (perf_ldstall_cnt !== 0 || perf_mdu_cnt !== 0) begin
            errors++;
            $display("FAIL reset_perf got %0d/%0d want 0/0",
                     perf_ldstall_cnt, perf_mdu_cnt);
        end
`endif
        @(posedge clk);
        #3;
        resetn = 1'b1;
        idle_in();
        tick();
    endtask

    task automatic test_load_use();
        set_in(5'd5, 5'd9, 1, 1, 5'd5, 1, 0, 0, 0, 0);
        checks++;
        if (outv !== V_LDUSE) begin
            errors++;
            $display("FAIL lw_use got %b want %b", outv, V_LDUSE);
        end
        tick();
        // Producer has moved to MEM: forwarding covers it.
        set_in(5'd5, 5'd9, 1, 1, 5'd0, 0, 0, 0, 0, 0);
        exp_v = model_eval();
        checks++;
        if (outv !== exp_v || outv !== V_NONE) begin
            errors++;
            $display("FAIL lw_use_1cyc got %b want %b", outv, V_NONE);
        end
        tick();
        set_in(5'd0, 5'd9, 1, 1, 5'd0, 1, 0, 0, 0, 0);
        checks++;
        if (outv !== V_NONE) begin
            errors++;
            $display("FAIL lw_r0 got %b want %b", outv, V_NONE);
        end
        tick();
        set_in(5'd5, 5'd9, 0, 1, 5'd5, 1, 0, 0, 0, 0);
        checks++;
        if (outv !== V_NONE) begin
            errors++;
            $display("FAIL lw_no_rs got %b want %b", outv, V_NONE);
        end
        tick();
    endtask

    task automatic test_mfc0();
        set_in(5'd1, 5'd7, 0, 1, 5'd7, 0, 1, 0, 0, 0);
        checks++;
        if (outv !== V_LDUSE) begin
            errors++;
            $display("FAIL mfc0_use got %b want %b", outv, V_LDUSE);
        end
        tick();
        set_in(5'd1, 5'd7, 0, 1, 5'd7, 0, 0, 0, 0, 0);
        checks++;
        if (outv !== V_NONE) begin
            errors++;
            $display("FAIL mfc0_none got %b want %b", outv, V_NONE);
        end
        tick();
    endtask

    task automatic run_mdu(input logic div, input string nm);
        int n;
        n = div ? DIV_N : MUL_N;
        for (int i = 0; i <= n; i++) begin
            set_in(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, i == 0, div, 0);
            exp_v = (i == 0) ? V_START :
                    (i < n - 1) ? V_MDUST :
                    (i == n - 1) ? V_DONE : V_NONE;
            checks++;
            if (outv !== exp_v || model_eval() !== exp_v) begin
                errors++;
                $display("FAIL %s cyc%0d got %b want %b",
                         nm, i, outv, exp_v);
            end
            tick();
        end
    endtask

    task automatic test_div_mul();
        run_mdu(1'b1, "div");
        run_mdu(1'b0, "mul");
    endtask

    task automatic test_exc_mid_div();
        bit saw_done;
        saw_done = 0;
        for (int i = 0; i <= 10; i++) begin
            set_in(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1, i == 10);
            exp_v = (i == 0) ? V_START : (i == 10) ? V_ABORT : V_MDUST;
            checks++;
            if (outv !== exp_v) begin
                errors++;
                $display("FAIL exc_div cyc%0d got %b want %b",
                         i, outv, exp_v);
            end
            tick();
        end
        idle_in();
        checks++;
        if (outv !== V_NONE) begin
            errors++;
            $display("FAIL exc_flush_cyc got %b want %b", outv, V_NONE);
        end
        for (int i = 0; i < 40; i++) begin
            tick();
            if (mdu_done === 1'b1) saw_done = 1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL exc_no_done got 1 want 0");
        end
    endtask

    task automatic test_exc_coincident();
        set_in(5'd3, 5'd0, 1, 0, 5'd3, 1, 0, 1, 1, 1);
        checks++;
        if (outv !== V_EXC) begin
            errors++;
            $display("FAIL exc_coinc got %b want %b", outv, V_EXC);
        end
        tick();
        set_in(5'd3, 5'd0, 1, 0, 5'd3, 1, 0, 1, 1, 0);
        checks++;
        if (outv !== V_NONE) begin
            errors++;
            $display("FAIL exc_coinc_flush got %b want %b", outv, V_NONE);
        end
        tick();
        idle_in();
        while (busy_left > 0) tick();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 2 * MUL_N; i++) begin
            set_in(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 0);
            exp_v = (i % MUL_N == 0) ? V_START :
                    (i % MUL_N == MUL_N - 1) ? V_DONE : V_MDUST;
            checks++;
            if (outv !== exp_v || model_eval() !== exp_v) begin
                errors++;
                $display("FAIL b2b cyc%0d got %b want %b", i, outv, exp_v);
            end
            tick();
        end
        idle_in();
        tick();
    endtask

    task automatic test_async_reset();
        set_in(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1, 0);
        tick();
        tick();
        tick();
        set_in(5'd4, 5'd0, 1, 0, 5'd4, 1, 0, 1, 1, 0);
        checks++;
        if (outv !== V_MDUST) begin
            errors++;
            $display("FAIL arst_pre got %b want %b", outv, V_MDUST);
        end
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        checks++;
        if (outv !== V_NONE) begin
            errors++;
            $display("FAIL arst_out got %b want %b", outv, V_NONE);
        end
`ifdef HAZARD_PERF_EN
        checks++;
        if (perf_ldstall_cnt !== 0 || perf_mdu_cnt !== 0) begin
            errors++;
            $display("FAIL arst_perf got %0d/%0d want 0/0",
                     perf_ldstall_cnt, perf_mdu_cnt);
        end
`endif
        @(posedge clk);
        #3;
        resetn = 1'b1;
        set_in(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 0);
        checks++;
        if (outv !== V_START) begin
            errors++;
            $display("FAIL arst_run got %b want %b", outv, V_START);
        end
        tick();
        idle_in();
        while (busy_left > 0) tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom), 1'($urandom),
                   5'($urandom_range(0, 3)), 1'($urandom),
                   1'($urandom_range(0, 3) == 0),
                   1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 3) == 0),
                   1'($urandom_range(0, 19) == 0));
            exp_v = model_eval();
            checks++;
            if (outv !== exp_v) begin
                errors++;
                $display("FAIL rand cyc%0d got %b want %b", i, outv, exp_v);
            end
            tick();
        end
`ifdef HAZARD_PERF_EN
        checks++;
        if (perf_ldstall_cnt !== m_ld || perf_mdu_cnt !== m_mdu) begin
            errors++;
            $display("FAIL rand_perf got %0d/%0d want %0d/%0d",
                     perf_ldstall_cnt, perf_mdu_cnt, m_ld, m_mdu);
        end
`endif
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_load_use();
        test_mfc0();
        test_div_mul();
        test_exc_mid_div();
        test_exc_coincident();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
